// File: rtl/gray_rr_arbiter.sv
// Four-requester round-robin arbiter whose priority ring follows Gray order 0,1,3,2.
// Define GRAY_ARB_TIMEOUT_EN to add a hold counter that force-releases a grant after TIMEOUT busy cycles.
module gray_rr_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic [1:0] ptr,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0] r_state;
    logic [3:0] r_grant;
    logic [1:0] r_grant_id;
    logic       r_busy;
    logic [1:0] r_ptr;

    logic [1:0] w_ptr_slot;
    logic       w_found;
    logic [1:0] w_win_id;
    logic       w_release_req;
    logic       w_release;

    // Slot s in the ring is served by requester s ^ (s >> 1).
    function automatic logic [1:0] slot_code(input logic [1:0] s);
        return s ^ (s >> 1);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_ptr_slot = {r_ptr[1], r_ptr[1] ^ r_ptr[0]};
        w_found    = 1'b0;
        w_win_id   = 2'd0;
        // k = 4 wraps back to the last winner's own slot, making it lowest priority.
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req[slot_code(w_ptr_slot + 2'(k))]) begin
                w_found  = 1'b1;
                w_win_id = slot_code(w_ptr_slot + 2'(k));
            end
        end
    end

    assign w_release_req = done || !req[r_grant_id];

`ifdef GRAY_ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_timeout;
    logic       w_force;

    // A normal release on the same edge wins over the forced one, so no pulse then.
    assign w_force   = (r_state == ST_BUSY) && (r_hold == 8'(TIMEOUT - 1)) && !w_release_req;
    assign w_release = w_release_req || w_force;
    assign timeout   = r_timeout;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_hold    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_hold <= 8'd0;
            end else if (w_force) begin
                r_timeout <= 1'b1;
                r_hold    <= 8'd0;
            end else if (!w_release) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end
`else
    assign w_release = w_release_req;
    assign timeout   = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'd0;
            r_busy     <= 1'b0;
            r_ptr      <= 2'b10;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_BUSY;
                        r_grant    <= 4'b0001 << w_win_id;
                        r_grant_id <= w_win_id;
                        r_busy     <= 1'b1;
                        r_ptr      <= w_win_id;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_grant    <= 4'b0000;
                        r_grant_id <= 2'd0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant    <= 4'b0000;
                    r_grant_id <= 2'd0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign ptr      = r_ptr;

endmodule

// File: tb/tb_gray_rr_arbiter.sv
// Directed bench for gray_rr_arbiter in its default build (hold-counter feature disabled).
// Expected values are hand-derived from the Gray priority ring 0,1,3,2.
module tb_gray_rr_arbiter;

    logic       clock;
    logic       clear;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic [1:0] ptr;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    gray_rr_arbiter #(.TIMEOUT(4)) dut (
        .clock    (clock),
        .clear    (clear),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .ptr      (ptr),
        .timeout  (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output against one expected snapshot.
    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic [1:0] p);
        check({tag, ".grant"},    8'(grant),    8'(g));
        check({tag, ".grant_id"}, 8'(grant_id), 8'(id));
        check({tag, ".busy"},     8'(busy),     8'(b));
        check({tag, ".ptr"},      8'(ptr),      8'(p));
        check({tag, ".timeout"},  8'(timeout),  8'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g [4];
        logic [1:0] exp_p [4];
        exp_g = '{4'b0010, 4'b1000, 4'b0100, 4'b0001};
        exp_p = '{2'b01,   2'b11,   2'b10,   2'b00};

        // Reset for 10 ns, then all four request.
        clear = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        #10;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 2'b10);
        #2;
        clear = 1'b0;
        req   = 4'b1111;
        tick();
        check_out("first_grant", 4'b0001, 2'd0, 1'b1, 2'b00);

        // done held high: release, idle gap, next in Gray order; done in IDLE is ignored.
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("rot_idle%0d", i), 4'b0000, 2'd0, 1'b0, (i == 0) ? 2'b00 : exp_p[i-1]);
            tick();
            check_out($sformatf("rot_grant%0d", i), exp_g[i],
                      (exp_g[i] == 4'b0001) ? 2'd0 : (exp_g[i] == 4'b0010) ? 2'd1 :
                      (exp_g[i] == 4'b0100) ? 2'd2 : 2'd3, 1'b1, exp_p[i]);
        end

        // Owner 0 releases; requester 1 wins next and holds while others toggle.
        tick();
        check_out("pre_hold_idle", 4'b0000, 2'd0, 1'b0, 2'b00);
        done = 1'b0;
        tick();
        check_out("hold_grant", 4'b0010, 2'd1, 1'b1, 2'b01);
        req = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("hold%0d", i), 4'b0010, 2'd1, 1'b1, 2'b01);
            req = (i % 2 == 0) ? 4'b0011 : 4'b1011;
        end
        req = 4'b1001;
        tick();
        check_out("drop_release", 4'b0000, 2'd0, 1'b0, 2'b01);
        tick();
        check_out("after_drop", 4'b1000, 2'd3, 1'b1, 2'b11);

        // Single requester 0 with done held: re-granted every second cycle.
        req  = 4'b0001;
        done = 1'b1;
        tick();
        check_out("solo_release", 4'b0000, 2'd0, 1'b0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("solo_grant%0d", i), 4'b0001, 2'd0, 1'b1, 2'b00);
            tick();
            check_out($sformatf("solo_idle%0d", i), 4'b0000, 2'd0, 1'b0, 2'b00);
        end

        // Requester 3 takes the grant, then clear drops it without a clock edge.
        done = 1'b0;
        req  = 4'b1000;
        tick();
        check_out("r3_grant", 4'b1000, 2'd3, 1'b1, 2'b11);
        #2;
        clear = 1'b1;
        #1;
        check_out("async_clear", 4'b0000, 2'd0, 1'b0, 2'b10);
        #1;
        clear = 1'b0;
        req   = 4'b0100;
        tick();
        check_out("post_clear", 4'b0100, 2'd2, 1'b1, 2'b10);

        // Without the timeout feature requester 0 holds indefinitely.
        req = 4'b0011;
        tick();
        check_out("r2_drop", 4'b0000, 2'd0, 1'b0, 2'b10);
        tick();
        check_out("to_grant", 4'b0001, 2'd0, 1'b1, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("no_timeout%0d", i), 4'b0001, 2'd0, 1'b1, 2'b00);
        end
        done = 1'b1;
        tick();
        check_out("final_release", 4'b0000, 2'd0, 1'b0, 2'b00);
        done = 1'b0;
        tick();
        check_out("final_grant", 4'b0010, 2'd1, 1'b1, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
